btn_event_gen: RTL

- Turns the debounced button levels into discrete game-input events.
- A press emits one event; holding the button emits auto-repeat events (typematic).
- Events from all buttons are queued as pending bits and presented one at a time to the game logic over a valid/ready handshake.
- Sits between the debouncers (one per button, all on the_clk) and the player-movement/bomb-drop logic.

---
 rtl/game_input_pkg.sv | 21 ++
 rtl/btn_event_gen_if.sv | 22 ++
 rtl/btn_repeat_fsm.sv | 78 +++++++
 rtl/btn_event_gen.sv | 82 ++++++++
 4 files changed

// File: rtl/game_input_pkg.sv
// Shared game-input definitions: button indices, event widths and the
// per-button repeat FSM state encoding.
package game_input_pkg;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_BOMB  = 4;

  localparam int unsigned NBTN   = 5;
  localparam int unsigned CODE_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRepeat,
    StHold
  } btn_state_e;

endpackage

// File: rtl/btn_event_gen_if.sv
// Button-level inputs and the event valid/ready handshake toward game logic.
interface btn_event_gen_if #(
  parameter int unsigned NBTN   = game_input_pkg::NBTN,
  parameter int unsigned CODE_W = game_input_pkg::CODE_W
);
  logic [NBTN-1:0]   btn_crt;
  logic              evt_valid;
  logic [CODE_W-1:0] evt_code;
  logic              evt_ready;
  logic [NBTN-1:0]   btn_held;
  logic              evt_drop;

  modport master (
    input  btn_crt, evt_ready,
    output evt_valid, evt_code, btn_held, evt_drop
  );

  modport slave (
    output btn_crt, evt_ready,
    input  evt_valid, evt_code, btn_held, evt_drop
  );
endinterface

// File: rtl/btn_repeat_fsm.sv
// Per-button typematic generator: one tick on press, then auto-repeat ticks
// after an initial delay while the button stays down.
module btn_repeat_fsm
  import game_input_pkg::*;
#(
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned REPEAT_DELAY  = 10_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000
) (
  input  logic the_clk,
  input  logic rst,
  input  logic btn,
  output logic tick,
  output logic held
);

  // Terminal counts; guarded so a zero delay does not underflow.
  localparam logic [CNT_W-1:0] DelayLast =
    CNT_W'((REPEAT_DELAY == 0) ? 0 : REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PeriodLast =
    CNT_W'((REPEAT_PERIOD == 0) ? 0 : REPEAT_PERIOD - 1);

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge the_clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick    = 1'b0;
    if (!btn) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: begin
          tick    = 1'b1;
          state_d = (REPEAT_DELAY != 0) ? StDelay : StHold;
          cnt_d   = '0;
        end
        StDelay: begin
          if (cnt_q == DelayLast) begin
            tick    = 1'b1;
            state_d = StRepeat;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRepeat: begin
          if (cnt_q == PeriodLast) begin
            tick  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StHold: ;
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign held = (state_q != StIdle);

endmodule

// File: rtl/btn_event_gen.sv
// Converts debounced button levels into queued press/repeat events presented
// one at a time, lowest button index first.
module btn_event_gen #(
  parameter int unsigned NBTN          = game_input_pkg::NBTN,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned REPEAT_DELAY  = 10_000_000,
  parameter int unsigned REPEAT_PERIOD = 2_500_000,
  parameter int unsigned CODE_W        = game_input_pkg::CODE_W
) (
  input logic             the_clk,
  input logic             rst,
  btn_event_gen_if.master bus
);

  logic [NBTN-1:0]   tick;
  logic [NBTN-1:0]   held;
  logic [NBTN-1:0]   pending_q, pending_d;
  logic [NBTN-1:0]   consume;
  logic              valid_q, valid_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              drop_q, drop_d;
  logic              load;
  logic              found;
  logic [CODE_W-1:0] sel_code;

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_repeat_fsm #(
      .CNT_W        (CNT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_fsm (
      .the_clk(the_clk),
      .rst    (rst),
      .btn    (bus.btn_crt[i]),
      .tick   (tick[i]),
      .held   (held[i])
    );
  end

  always_comb begin
    load     = !valid_q || bus.evt_ready;
    found    = 1'b0;
    sel_code = '0;
    consume  = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (pending_q[i] && !found) begin
        found      = 1'b1;
        sel_code   = CODE_W'(i);
        consume[i] = load;
      end
    end
    // A tick landing on the bit being consumed re-sets it: set wins.
    pending_d = (pending_q & ~consume) | tick;
    drop_d    = drop_q | (|(tick & pending_q & ~consume));
    valid_d   = valid_q;
    code_d    = code_q;
    if (load) begin
      valid_d = found;
      if (found) code_d = sel_code;
    end
  end

  always_ff @(posedge the_clk) begin
    if (rst) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.evt_valid = valid_q;
  assign bus.evt_code  = code_q;
  assign bus.evt_drop  = drop_q;
  assign bus.btn_held  = held;

endmodule
